// File: rtl/pong_btn_debounce.sv
// pong_btn_debounce: two-flop synchronizer plus per-channel debounce FSM for the pong paddle buttons.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   btn_raw  - raw asynchronous button levels, 1 = pressed
//   db_level - debounced, registered level per channel
//   db_tick  - one-clk pulse per accepted press (0->1) per channel
module pong_btn_debounce #(
    parameter int N_BTN    = 2,
    parameter int DB_TICKS = 1_000_000,
    parameter int CNT_W    = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] db_level,
    output logic [N_BTN-1:0] db_tick
);
    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;
    logic [N_BTN-1:0] s1, s2;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end
    for (genvar g = 0; g < N_BTN; g++) begin : ch
        state_t state, state_nx;
        logic [CNT_W-1:0] cnt, cnt_nx;
        logic lvl, tck, done;
        assign done = cnt == CNT_W'(DB_TICKS - 1);
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            case (state)
                ZERO:  if (s2[g]) begin
                           state_nx = WAIT1;
                           cnt_nx   = '0;
                       end
                WAIT1: if (!s2[g]) state_nx = ZERO;
                       else if (done) state_nx = ONE;
                       else cnt_nx = cnt + CNT_W'(1);
                ONE:   if (!s2[g]) begin
                           state_nx = WAIT0;
                           cnt_nx   = '0;
                       end
                WAIT0: if (s2[g]) state_nx = ONE;
                       else if (done) state_nx = ZERO;
                       else cnt_nx = cnt + CNT_W'(1);
                default: state_nx = ZERO;
            endcase
        end
        // Outputs are registered from the next state so they line up with the state register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state <= ZERO;
                cnt   <= '0;
                lvl   <= 1'b0;
                tck   <= 1'b0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                lvl   <= state_nx == ONE || state_nx == WAIT0;
                tck   <= state == WAIT1 && state_nx == ONE;
            end
        end
        assign db_level[g] = lvl;
        assign db_tick[g]  = tck;
    end
endmodule

// File: doc/pong_btn_debounce.md
Name: pong_btn_debounce

Overview:
Debounce and synchronize stage directly upstream of the pong graphics/animation generator's btn[1:0] input. It takes raw, bouncing, asynchronous push-button levels and produces clean, clk-synchronous levels. It also produces one-cycle press ticks, so paddle motion never sees glitches or metastable values.
One instance serves both paddle buttons. Each channel is fully independent.

Parameters:
N_BTN, 2, number of button channels.
DB_TICKS, 1_000_000, stable-sample count required to accept a new level (20 ms at 50 MHz); must be >= 2.
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W >= DB_TICKS.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
btn_raw  input  N_BTN  raw asynchronous button levels, 1 = pressed.
db_level  output  N_BTN  debounced level per channel; drives the graphics generator's btn.
db_tick  output  N_BTN  one-clk pulse on each accepted press (0->1) per channel.

Behaviour:
- Reset (reset=0, async): synchronizer flops, counters and FSMs go to 0 / ZERO; db_level=0, db_tick=0. Release is sampled on the next rising clk.
- Synchronizer: per channel, two flops. s1<=btn_raw, s2<=s1. Only s2 feeds the FSM.
- Per-channel FSM, states ZERO, WAIT1, ONE, WAIT0. One CNT_W counter per channel.
  - ZERO: s2=1 -> WAIT1, cnt<=0. Otherwise stay.
  - WAIT1: s2=0 -> ZERO (bounce rejected, no tick). s2=1 and cnt==DB_TICKS-1 -> ONE. Otherwise cnt<=cnt+1.
  - ONE: s2=0 -> WAIT0, cnt<=0. Otherwise stay.
  - WAIT0: s2=1 -> ONE (release bounce rejected, no tick). s2=0 and cnt==DB_TICKS-1 -> ZERO. Otherwise cnt<=cnt+1.
- Outputs are registered, with no combinational path from btn_raw.
  - db_level=1 exactly while state is ONE or WAIT0.
  - db_tick=1 for exactly the first clk in which state is ONE after arriving from WAIT1. It is 0 when returning to ONE from WAIT0.
- Latency: btn_raw rising and held steady, first sampled at edge k -> db_level and db_tick asserted after edge k+DB_TICKS+2. Release is symmetric: db_level drops after edge k+DB_TICKS+2, with no tick.
- The counter never wraps. It is reset on every entry into WAIT1/WAIT0 and compared for equality with DB_TICKS-1.
- Any glitch shorter than DB_TICKS clocks (after synchronization) leaves db_level unchanged and produces no tick.
- Channels are independent. Simultaneous presses on both channels give simultaneous ticks in the same cycle.
- Reset asserted mid-count (any state) forces ZERO immediately.
  - If btn_raw is still high after release, a fresh full DB_TICKS qualification is required.
  - No tick is issued on reset release unless qualification completes.

Test Plan:
- DB_TICKS=8: reset low then high, btn_raw=00 -> db_level=00, db_tick=00 for 50 cycles.
- DB_TICKS=8: btn_raw[0] 0->1 held -> db_level[0]=1 and db_tick[0]=1 10 clks after first sampling edge. db_tick[0] back to 0 next clk. Channel 1 untouched.
- Bounce on press: btn_raw[1] toggles 1,0,1,0 every 3 clks, then held 1 -> no tick during bouncing. A single tick and level=1 arrive 10 clks after the final stable 1 is sampled.
- Release with bounce: from ONE, btn_raw[0]=0 for 5 clks then 1 -> db_level stays 1, no tick. Then held 0 for 20 clks -> db_level=0 10 clks after the last 0-edge start, no tick.
- Simultaneous: btn_raw=11 applied on the same edge -> db_tick=11 in the same cycle, db_level=11.
- Reset mid-operation: btn_raw[0]=1 held, reset pulsed low at cnt=5 -> db_level/db_tick=0 asynchronously. After release, the tick arrives a full 10 clks after reset deassertion.
